// File: rtl/vdp_tile_fetch.sv
// vdp_tile_fetch: tile-based pixel generator downstream of vgasync.
// Fetches name/pattern/color bytes per tile from VRAM and shifts out
// 4-bit color indices, with sync/active delayed by LAT pixel clocks.
module vdp_tile_fetch #(
  parameter int unsigned LAT = 8,
  parameter int unsigned AW  = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          text_mode,
  input  logic [8:0]    px_col,
  input  logic [7:0]    px_row,
  input  logic          px_active,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [3:0]    reg_name,
  input  logic [7:0]    reg_color,
  input  logic [2:0]    reg_patt,
  input  logic [7:0]    reg_fgbg,
  output logic [AW-1:0] vram_addr,
  output logic          vram_rd,
  input  logic [7:0]    vram_data,
  output logic [3:0]    pix_color,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_active
);

  localparam int unsigned SUB_W = 3;
  localparam int unsigned TX_W  = 6;

  typedef enum logic [1:0] {S_IDLE, S_NAME, S_PATT, S_COLR} state_e;

  state_e state_q, state_d, prev_q;

  logic              active_q, armed_q, mode_q;
  logic [SUB_W-1:0]  sub_q, sub_d, sub_c;
  logic [TX_W-1:0]   tx_q, tx_d, tx_c, last_c;
  logic              rise_c, mode_c, wrap_c, tile_start_c;

  logic [3:0]        f_name_q;
  logic [2:0]        f_patt_q;
  logic [7:0]        f_color_q, f_fgbg_q, f_row_q;
  logic [TX_W-1:0]   f_tx_q;
  logic              f_mode_q;
  logic [AW-1:0]     row_w;

  logic [7:0]        name_q, next_patt_q, next_color_q, next_fgbg_q;
  logic              next_mode_q, next_valid_q, fetch_done_c;

  logic [7:0]        sh_q, cur_color_q, cur_fgbg_q;
  logic              cur_mode_q, cur_valid_q;
  logic [LAT-2:0]    ts_q;
  logic [LAT-1:0]    hs_q, vs_q, act_q;
  logic [3:0]        pix_q, pix_d, idx_c;
  logic              load_c, bit_c, mode_sel_c, valid_sel_c;
  logic [7:0]        color_sel_c, fgbg_sel_c;

  // Tile counting: sub/tx restart on the px_active rise, mode latched there too.
  always_comb begin
    rise_c       = px_active & ~active_q & armed_q;
    mode_c       = rise_c ? text_mode : mode_q;
    sub_c        = rise_c ? '0 : sub_q;
    tx_c         = rise_c ? '0 : tx_q;
    wrap_c       = (sub_c == (mode_c ? SUB_W'(5) : SUB_W'(7)));
    last_c       = mode_c ? TX_W'(39) : TX_W'(31);
    tile_start_c = px_active & armed_q & (sub_c == '0) & (tx_c <= last_c)
                   & (px_col < (mode_c ? 9'd240 : 9'd256));
    sub_d        = sub_q;
    tx_d         = tx_q;
    if (px_active) begin
      sub_d = wrap_c ? '0 : sub_c + SUB_W'(1);
      tx_d  = (wrap_c && tx_c <= last_c) ? tx_c + TX_W'(1) : tx_c;
    end
  end

  // Line tracking; armed_q blocks a spurious restart when reset drops mid-line.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      armed_q  <= 1'b0;
      mode_q   <= 1'b0;
      sub_q    <= '0;
      tx_q     <= '0;
    end else begin
      active_q <= px_active;
      armed_q  <= armed_q | ~px_active;
      mode_q   <= mode_c;
      sub_q    <= sub_d;
      tx_q     <= tx_d;
    end
  end

  // Snapshot of registers and coordinates taken at tile start.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_name_q  <= '0;
      f_patt_q  <= '0;
      f_color_q <= '0;
      f_fgbg_q  <= '0;
      f_row_q   <= '0;
      f_tx_q    <= '0;
      f_mode_q  <= 1'b0;
    end else if (tile_start_c) begin
      f_name_q  <= reg_name;
      f_patt_q  <= reg_patt;
      f_color_q <= reg_color;
      f_fgbg_q  <= reg_fgbg;
      f_row_q   <= px_row;
      f_tx_q    <= tx_c;
      f_mode_q  <= mode_c;
    end
  end

  // Fetch FSM state register; prev_q tags which read the current vram_data answers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      prev_q  <= S_IDLE;
    end else begin
      state_q <= state_d;
      prev_q  <= state_q;
    end
  end

  // Fetch FSM next state and VRAM request; pattern address uses the name byte as it returns.
  always_comb begin
    state_d   = state_q;
    vram_rd   = 1'b0;
    vram_addr = '0;
    row_w     = AW'(f_row_q[7:3]);
    case (state_q)
      S_IDLE: if (tile_start_c) state_d = S_NAME;
      S_NAME: begin
        vram_rd   = 1'b1;
        vram_addr = f_mode_q ? AW'({f_name_q, 10'b0}) + (row_w << 5) + (row_w << 3) + AW'(f_tx_q)
                             : AW'({f_name_q, f_row_q[7:3], f_tx_q[4:0]});
        state_d   = S_PATT;
      end
      S_PATT: begin
        vram_rd   = 1'b1;
        vram_addr = AW'({f_patt_q, vram_data, f_row_q[2:0]});
        state_d   = f_mode_q ? S_IDLE : S_COLR;
      end
      S_COLR: begin
        vram_rd   = 1'b1;
        vram_addr = AW'({f_color_q, 1'b0, name_q[7:3]});
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!px_active) state_d = S_IDLE;
  end

  assign fetch_done_c = (prev_q == S_COLR) | ((prev_q == S_PATT) & f_mode_q);

  // Capture returning bytes into the next_* holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      name_q       <= '0;
      next_patt_q  <= '0;
      next_color_q <= '0;
      next_fgbg_q  <= '0;
      next_mode_q  <= 1'b0;
      next_valid_q <= 1'b0;
    end else begin
      case (prev_q)
        S_NAME:  name_q       <= vram_data;
        S_PATT:  next_patt_q  <= vram_data;
        S_COLR:  next_color_q <= vram_data;
        default: ;
      endcase
      if (fetch_done_c) begin
        next_valid_q <= 1'b1;
        next_mode_q  <= f_mode_q;
        next_fgbg_q  <= f_fgbg_q;
      end else if (load_c) begin
        next_valid_q <= 1'b0;
      end
    end
  end

  // Pixel select for the next output clock; an incomplete tile shows backdrop.
  always_comb begin
    load_c      = ts_q[LAT-2];
    bit_c       = load_c ? next_patt_q[7] : sh_q[7];
    color_sel_c = load_c ? next_color_q : cur_color_q;
    fgbg_sel_c  = load_c ? next_fgbg_q : cur_fgbg_q;
    mode_sel_c  = load_c ? next_mode_q : cur_mode_q;
    valid_sel_c = load_c ? next_valid_q : cur_valid_q;
    if (mode_sel_c) idx_c = bit_c ? fgbg_sel_c[7:4] : fgbg_sel_c[3:0];
    else            idx_c = bit_c ? color_sel_c[7:4] : color_sel_c[3:0];
    if (idx_c == 4'd0) idx_c = fgbg_sel_c[3:0];
    pix_d = (act_q[LAT-2] && valid_sel_c) ? idx_c : reg_fgbg[3:0];
  end

  // Shifter, current-tile registers, output pixel and LAT delay lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q        <= '0;
      cur_color_q <= '0;
      cur_fgbg_q  <= '0;
      cur_mode_q  <= 1'b0;
      cur_valid_q <= 1'b0;
      pix_q       <= '0;
      ts_q        <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
      act_q       <= '0;
    end else begin
      if (load_c) begin
        sh_q        <= {next_patt_q[6:0], 1'b0};
        cur_color_q <= next_color_q;
        cur_fgbg_q  <= next_fgbg_q;
        cur_mode_q  <= next_mode_q;
        cur_valid_q <= next_valid_q;
      end else begin
        sh_q <= {sh_q[6:0], 1'b0};
      end
      pix_q <= pix_d;
      ts_q  <= {ts_q[LAT-3:0], tile_start_c};
      hs_q  <= {hs_q[LAT-2:0], hsync};
      vs_q  <= {vs_q[LAT-2:0], vsync};
      act_q <= {act_q[LAT-2:0], px_active};
    end
  end

  assign pix_color = pix_q;
  assign o_hsync   = hs_q[LAT-1];
  assign o_vsync   = vs_q[LAT-1];
  assign o_active  = act_q[LAT-1];

endmodule

// File: tb/tb_vdp_tile_fetch.sv
// Directed bench for vdp_tile_fetch: VRAM model, per-line logging, hand-computed expectations.
module tb_vdp_tile_fetch;

  localparam int unsigned AW  = 14;
  localparam int unsigned LAT = 8;

  logic          clk = 1'b0;
  logic          reset, text_mode, px_active, hsync, vsync, vram_rd;
  logic          o_hsync, o_vsync, o_active;
  logic [8:0]    px_col;
  logic [7:0]    px_row, reg_color, reg_fgbg, vram_data;
  logic [3:0]    reg_name, pix_color;
  logic [2:0]    reg_patt;
  logic [AW-1:0] vram_addr;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] addr_log [0:511];
  logic          rd_log   [0:511];
  logic [3:0]    pix_log  [0:511];
  logic          act_log  [0:511];
  logic          hs_h [0:63];
  logic          vs_h [0:63];
  logic          ac_h [0:63];

  int n_checks = 0;
  int n_errors = 0;

  vdp_tile_fetch #(.LAT(LAT), .AW(AW)) dut (
    .clk(clk), .reset(reset), .text_mode(text_mode), .px_col(px_col), .px_row(px_row),
    .px_active(px_active), .hsync(hsync), .vsync(vsync), .reg_name(reg_name),
    .reg_color(reg_color), .reg_patt(reg_patt), .reg_fgbg(reg_fgbg),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
    .pix_color(pix_color), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_active(o_active)
  );

  always #5 clk = ~clk;

  // VRAM: read data returns one clock after the strobe.
  always @(posedge clk) if (vram_rd) vram_data <= mem[vram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One line: index 0 is the px_active rise; 16 blanking clocks follow.
  task automatic run_line(input logic tm, input logic [7:0] row, input int ncols, input int rst_at);
    for (int i = 0; i < ncols + 16; i++) begin
      tick();
      px_active = (i < ncols);
      px_col    = 9'(i);
      px_row    = row;
      text_mode = tm;
      reset     = (rst_at >= 0 && i >= rst_at && i < rst_at + 4);
      #1;
      addr_log[i] = vram_addr;
      rd_log[i]   = vram_rd;
      pix_log[i]  = pix_color;
      act_log[i]  = o_active;
    end
  endtask

  function automatic int rd_count(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(rd_log[i]);
    return n;
  endfunction

  logic [3:0] exp_a [0:7];
  logic [3:0] exp_b [0:7];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    exp_a = '{4'h4, 4'hE, 4'h4, 4'hE, 4'hE, 4'h4, 4'hE, 4'h4};
    exp_b = '{4'h7, 4'hE, 4'h7, 4'hE, 4'hE, 4'h7, 4'hE, 4'h7};
    reset = 1'b1; text_mode = 1'b0; px_active = 1'b0; hsync = 1'b1; vsync = 1'b1;
    px_col = '0; px_row = '0; reg_name = '0; reg_color = '0; reg_patt = '0; reg_fgbg = 8'h12;
    repeat (3) tick();
    check("rst_pix", 32'(pix_color), 32'h0);
    check("rst_rd", 32'(vram_rd), 32'h0);
    check("rst_addr", 32'(vram_addr), 32'h0);
    check("rst_osync", 32'({o_hsync, o_vsync, o_active}), 32'h0);
    reset = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (4) tick();

    mem[14'h0422] = 8'h35;
    mem[14'h11A9] = 8'hA5;
    mem[14'h0806] = 8'h4E;
    mem[41]       = 8'h52;
    mem[14'h1290] = 8'hFC;
    reg_name = 4'd1; reg_patt = 3'd2; reg_color = 8'h20;

    // Reset held 4 clocks mid-line
    run_line(1'b0, 8'd9, 264, 100);
    check("mid_act_before", 32'(act_log[99]), 32'h1);
    check("mid_rst_pix", 32'(pix_log[102]), 32'h0);
    check("mid_rst_act", 32'(act_log[102]), 32'h0);
    check("mid_rst_last_act", 32'(act_log[104]), 32'h0);
    check("mid_rst_rd_after", 32'(rd_count(101, 279)), 32'h0);

    // Graphics fetch and pixels, restarting from tx=0
    run_line(1'b0, 8'd9, 264, -1);
    check("restart_addr", 32'(addr_log[1]), 32'h0420);
    check("restart_rd", 32'(rd_log[1]), 32'h1);
    check("gfx_name_addr", 32'(addr_log[17]), 32'h0422);
    check("gfx_name_rd", 32'(rd_log[17]), 32'h1);
    check("gfx_patt_addr", 32'(addr_log[18]), 32'h11A9);
    check("gfx_colr_addr", 32'(addr_log[19]), 32'h0806);
    check("gfx_rd_per_tile", 32'(rd_count(16, 23)), 32'd3);
    for (int k = 0; k < 8; k++) check($sformatf("gfx_pix%0d", k), 32'(pix_log[24 + k]), 32'(exp_a[k]));
    check("gfx_transp_bg", 32'(pix_log[20]), 32'h2);
    check("gfx_border", 32'(pix_log[3]), 32'h2);
    check("gfx_last_tile_addr", 32'(addr_log[249]), 32'h043F);
    check("gfx_no_fetch_past_end", 32'(rd_count(252, 279)), 32'h0);

    // Transparent color nibble replaced by backdrop
    mem[14'h0806] = 8'h0E; reg_fgbg = 8'h17;
    run_line(1'b0, 8'd9, 264, -1);
    for (int k = 0; k < 8; k++) check($sformatf("transp_pix%0d", k), 32'(pix_log[24 + k]), 32'(exp_b[k]));
    check("transp_zero_tile", 32'(pix_log[20]), 32'h7);

    // Text mode
    reg_name = 4'd0; reg_fgbg = 8'hF1;
    run_line(1'b1, 8'd8, 240, -1);
    check("txt_name_addr", 32'(addr_log[7]), 32'd41);
    check("txt_patt_addr", 32'(addr_log[8]), 32'h1290);
    check("txt_rd_per_tile", 32'(rd_count(6, 11)), 32'd2);
    for (int k = 0; k < 6; k++) check($sformatf("txt_pix%0d", k), 32'(pix_log[14 + k]), 32'hF);
    check("txt_prev_tile_bg", 32'(pix_log[13]), 32'h1);
    check("txt_next_tile_bg", 32'(pix_log[20]), 32'h1);
    check("txt_last_tile_addr", 32'(addr_log[235]), 32'd79);

    // Random sync/active: outputs are the inputs LAT clocks earlier
    reg_fgbg = 8'h5A;
    for (int j = 0; j < 64; j++) begin
      tick();
      hsync     = 1'($urandom_range(0, 1));
      vsync     = 1'($urandom_range(0, 1));
      px_active = 1'($urandom_range(0, 1));
      px_col    = 9'($urandom_range(0, 255));
      hs_h[j] = hsync; vs_h[j] = vsync; ac_h[j] = px_active;
      #1;
      if (j >= int'(LAT)) begin
        check($sformatf("dly_hs%0d", j), 32'(o_hsync), 32'(hs_h[j - LAT]));
        check($sformatf("dly_vs%0d", j), 32'(o_vsync), 32'(vs_h[j - LAT]));
        check($sformatf("dly_act%0d", j), 32'(o_active), 32'(ac_h[j - LAT]));
        if (!ac_h[j - LAT]) check($sformatf("dly_border%0d", j), 32'(pix_color), 32'hA);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
